// File: rtl/exec_trace_buffer_pkg.sv
// Shared types and field layout for the execution trace buffer.
// A trace entry is {pc, instr}; decoded fields follow the MIPS I-type layout.
package exec_trace_buffer_pkg;

  localparam int ENTRY_W = 64;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int OFF_MSB = 15;
  localparam int OFF_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/exec_trace_buffer_trace_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers; head slot is read combinationally.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/exec_trace_buffer.sv
// Snoops CPU PC/instruction per step into a FIFO for one capture window per start,
// then drains over a valid/ready stream with decoded instruction fields.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// CAPTURE | counting CPU steps and pushing them until CAPTURE_MAX
// DRAIN   | window closed, waiting for the FIFO to empty
// DONE    | window fully drained, start opens a new one
module exec_trace_buffer
  import exec_trace_buffer_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int CAPTURE_MAX = 51
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cpu_step,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [15:0] out_offset,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] step_count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] CAP_MAX = 16'(CAPTURE_MAX);

  state_e       state_q;
  logic [15:0]  step_count_q;
  logic         overflow_q;

  trace_entry_t wr_entry, head_entry;
  logic         fifo_full, fifo_empty;
  logic [AW:0]  fifo_level;
  logic         pop, step_ok, push, drop, last_step, drain_last;

  assign wr_entry   = '{pc: cpu_pc, instr: cpu_instr};
  assign pop        = out_valid && out_ready;
  assign step_ok    = (state_q == ST_CAPTURE) && cpu_step;
  assign push       = step_ok && (!fifo_full || pop);
  assign drop       = step_ok && fifo_full && !pop;
  assign last_step  = (step_count_q + 16'd1) == CAP_MAX;
  // Lets done rise right after the final pop instead of one cycle later.
  assign drain_last = fifo_empty || ((fifo_level == (AW+1)'(1)) && pop);

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      step_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_CAPTURE;
            step_count_q <= '0;
            overflow_q   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (cpu_step) begin
            step_count_q <= step_count_q + 16'd1;
            if (drop)      overflow_q <= 1'b1;
            if (last_step) state_q    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_last) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = !fifo_empty;
  assign out_pc     = head_entry.pc;
  assign out_instr  = head_entry.instr;
  assign out_opcode = head_entry.instr[OPC_MSB:OPC_LSB];
  assign out_rs     = head_entry.instr[RS_MSB:RS_LSB];
  assign out_rt     = head_entry.instr[RT_MSB:RT_LSB];
  assign out_offset = head_entry.instr[OFF_MSB:OFF_LSB];
  assign busy       = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign overflow   = overflow_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Drives two trace buffers (window 51 and window 70) with shared stimulus and
// compares every cycle against a queue-based reference of the capture/drain rules.
module tb_exec_trace_buffer;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset, start, cpu_step, out_ready;
  logic [31:0] cpu_pc, cpu_instr;

  logic        o_valid [2];
  logic [31:0] o_pc    [2];
  logic [31:0] o_instr [2];
  logic [5:0]  o_opc   [2];
  logic [4:0]  o_rs    [2];
  logic [4:0]  o_rt    [2];
  logic [15:0] o_off   [2];
  logic        o_busy  [2];
  logic        o_done  [2];
  logic        o_ovf   [2];
  logic [15:0] o_sc    [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  exec_trace_buffer #(.DEPTH(DEPTH), .CAPTURE_MAX(51)) dut_a (
    .clk(clk), .reset(reset), .start(start), .cpu_step(cpu_step),
    .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_pc(o_pc[0]), .out_instr(o_instr[0]), .out_opcode(o_opc[0]), .out_rs(o_rs[0]),
    .out_rt(o_rt[0]), .out_offset(o_off[0]), .busy(o_busy[0]), .done(o_done[0]),
    .overflow(o_ovf[0]), .step_count(o_sc[0]));

  exec_trace_buffer #(.DEPTH(DEPTH), .CAPTURE_MAX(70)) dut_b (
    .clk(clk), .reset(reset), .start(start), .cpu_step(cpu_step),
    .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_pc(o_pc[1]), .out_instr(o_instr[1]), .out_opcode(o_opc[1]), .out_rs(o_rs[1]),
    .out_rt(o_rt[1]), .out_offset(o_off[1]), .busy(o_busy[1]), .done(o_done[1]),
    .overflow(o_ovf[1]), .step_count(o_sc[1]));

  // Reference: phase 0 idle, 1 capturing, 2 draining, 3 drained.
  for (genvar g = 0; g < 2; g++) begin : g_ref
    localparam int MAXV = (g == 0) ? 51 : 70;
    logic [63:0] q[$];
    int cnt = 0;
    int ph  = 0;
    bit ovf = 1'b0;

    always @(posedge clk) begin
      bit pop, cand;
      int p0;
      if (!reset) begin
        q.delete(); cnt = 0; ph = 0; ovf = 1'b0;
      end else begin
        p0   = ph;
        pop  = (q.size() > 0) && out_ready;
        cand = (p0 == 1) && cpu_step;
        if (pop) void'(q.pop_front());
        if (cand) begin
          cnt++;
          if (q.size() < DEPTH) q.push_back({cpu_pc, cpu_instr});
          else ovf = 1'b1;
        end
        if ((p0 == 0 || p0 == 3) && start) begin
          ph = 1; cnt = 0; ovf = 1'b0;
        end else if (cand && cnt == MAXV) ph = 2;
        else if (p0 == 2 && q.size() == 0) ph = 3;
      end
    end

    always @(negedge clk) begin
      logic [63:0] h;
      if (chk_en) begin
        chk($sformatf("valid%0d", g), 64'(o_valid[g]), 64'(q.size() > 0));
        chk($sformatf("busy%0d", g), 64'(o_busy[g]), 64'(ph == 1 || ph == 2));
        chk($sformatf("done%0d", g), 64'(o_done[g]), 64'(ph == 3));
        chk($sformatf("ovf%0d", g), 64'(o_ovf[g]), 64'(ovf));
        chk($sformatf("steps%0d", g), 64'(o_sc[g]), 64'(cnt));
        if (q.size() > 0) begin
          h = q[0];
          chk($sformatf("head%0d", g), {o_pc[g], o_instr[g]}, h);
          chk($sformatf("fields%0d", g), 64'({o_opc[g], o_rs[g], o_rt[g], o_off[g]}),
              64'({h[31:26], h[25:21], h[20:16], h[15:0]}));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; cpu_step = 1'b0; tick(); start = 1'b0;
  endtask

  task automatic run_random_to_done(input bit rand_pc);
    int budget = 3000;
    while (!(o_done[0] && o_done[1]) && budget > 0) begin
      cpu_step  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cpu_pc    = rand_pc ? $urandom : cpu_pc + 32'd4;
      cpu_instr = $urandom;
      tick();
      budget--;
    end
    if (budget == 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int na, nb, budget, steps_b;
    bit last_a;
    reset = 1'b0; start = 1'b0; cpu_step = 1'b0; out_ready = 1'b0;
    cpu_pc = '0; cpu_instr = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); cpu_step = 1'($urandom); out_ready = 1'($urandom);
      cpu_pc = $urandom; cpu_instr = $urandom;
      tick();
      chk_en = 1'b1;
    end
    chk("rst_valid", 64'(o_valid[0]), 64'd0);
    chk("rst_busy", 64'(o_busy[0]), 64'd0);
    chk("rst_done", 64'(o_done[1]), 64'd0);
    chk("rst_ovf", 64'(o_ovf[1]), 64'd0);
    chk("rst_steps", 64'(o_sc[0]), 64'd0);

    // Sequential PCs under full back-pressure: window 51 fits, window 70 overflows.
    reset = 1'b1; out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 70; i++) begin
      cpu_pc = 32'(i * 4); cpu_instr = $urandom; cpu_step = 1'b1;
      tick();
    end
    cpu_step = 1'b0;
    chk("a_drain_busy", 64'(o_busy[0]), 64'd1);
    chk("a_drain_done", 64'(o_done[0]), 64'd0);
    chk("a_steps", 64'(o_sc[0]), 64'd51);
    chk("a_no_ovf", 64'(o_ovf[0]), 64'd0);
    chk("b_steps", 64'(o_sc[1]), 64'd70);
    chk("b_ovf", 64'(o_ovf[1]), 64'd1);

    out_ready = 1'b1; na = 0; nb = 0; budget = 200;
    while (!(o_done[0] && o_done[1]) && budget > 0) begin
      last_a = 1'b0;
      if (o_valid[0]) begin
        chk("a_pop_pc", 64'(o_pc[0]), 64'(na * 4));
        na++;
        last_a = (na == 51);
      end
      if (o_valid[1]) begin
        chk("b_pop_pc", 64'(o_pc[1]), 64'(nb * 4));
        nb++;
      end
      tick();
      if (last_a) chk("a_done_after_last_pop", 64'(o_done[0]), 64'd1);
      budget--;
    end
    if (budget == 0) chk("drain_timeout", 64'd0, 64'd1);
    chk("a_pops", 64'(na), 64'd51);
    chk("b_pops", 64'(nb), 64'd64);

    // Fill to full, then keep it full with ready toggling and steps only on ready.
    pulse_start();
    out_ready = 1'b0; steps_b = 0;
    for (int i = 0; i < 64; i++) begin
      cpu_pc = 32'h1000 + 32'(i * 4); cpu_instr = $urandom; cpu_step = 1'b1;
      tick(); steps_b++;
    end
    for (int i = 0; i < 40 && steps_b < 70; i++) begin
      out_ready = 1'(i % 2);
      cpu_step  = out_ready;
      cpu_pc    = 32'h1000 + 32'(steps_b * 4); cpu_instr = $urandom;
      tick();
      if (cpu_step) steps_b++;
    end
    cpu_step = 1'b0;
    chk("b_full_no_ovf", 64'(o_ovf[1]), 64'd0);
    chk("b_full_steps", 64'(o_sc[1]), 64'd70);
    run_random_to_done(1'b0);

    // Field decode of a load word.
    pulse_start();
    out_ready = 1'b0; cpu_step = 1'b1; cpu_pc = 32'h400; cpu_instr = 32'h8C220004;
    tick();
    cpu_step = 1'b0;
    chk("dec_opcode", 64'(o_opc[0]), 64'h23);
    chk("dec_rs", 64'(o_rs[0]), 64'd1);
    chk("dec_rt", 64'(o_rt[0]), 64'd2);
    chk("dec_offset", 64'(o_off[0]), 64'h0004);
    run_random_to_done(1'b1);

    // Reset in the middle of a window, then a clean rerun.
    pulse_start();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cpu_pc = $urandom; cpu_instr = $urandom; cpu_step = 1'b1;
      tick();
    end
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(o_valid[0]), 64'd0);
    chk("mid_rst_steps", 64'(o_sc[0]), 64'd0);
    chk("mid_rst_busy", 64'(o_busy[1]), 64'd0);
    reset = 1'b1;
    pulse_start();
    run_random_to_done(1'b1);

    // Random windows.
    for (int w = 0; w < 4; w++) begin
      pulse_start();
      run_random_to_done(1'b1);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
